// File: rtl/wb_dcache_pkg.sv
// -----------------------------------------------------------------------------
// wb_dcache_pkg
// Shared types for the write-back data cache: the CPU word type, the
// cache controller state encoding and the address the hit counter is
// written to at the end of a flush.
// Optional feature macro: WB_DCACHE_HIT_COUNTER_EN adds the CNTWR state.
// -----------------------------------------------------------------------------
package wb_dcache_pkg;

    typedef logic [31:0] word_t;

    localparam word_t HIT_CNT_ADDR = 32'h0000_3100;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FETCH,
        FLUSH,
`ifdef WB_DCACHE_HIT_COUNTER_EN
        CNTWR,
`endif
        DONE
    } cache_state_t;

endpackage

// File: rtl/wb_dcache_lru.sv
// -----------------------------------------------------------------------------
// wb_dcache_lru
// Per-set LRU bit array for the 2-way configuration plus victim selection.
// The stored bit names the least recently used way of the set.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset (clears every LRU bit)
//   hit_i      a hit is served this cycle in set set_i, way hit_way_i
//   hit_way_i  way that hit
//   set_i      set addressed by the current request
//   valid_i    valid bits of both ways of set_i
//   victim_o   way to replace on a miss in set_i
// -----------------------------------------------------------------------------
module wb_dcache_lru #(
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hit_i,
    input  logic             hit_way_i,
    input  logic [IDX_W-1:0] set_i,
    input  logic [1:0]       valid_i,
    output logic             victim_o
);

    logic [SETS-1:0] lru_q, lru_d;

    // A hit makes the other way the least recently used one.
    always_comb begin
        lru_d = lru_q;
        if (hit_i) begin
            lru_d[set_i] = ~hit_way_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end

    // Invalid ways are filled first, lowest way first; otherwise the LRU way.
    always_comb begin
        if (!valid_i[0]) begin
            victim_o = 1'b0;
        end else if (!valid_i[1]) begin
            victim_o = 1'b1;
        end else begin
            victim_o = lru_q[set_i];
        end
    end

endmodule

// File: rtl/wb_dcache.sv
// -----------------------------------------------------------------------------
// wb_dcache
// Write-back, write-allocate data cache between the datapath data port and
// the memory controller data channel. 1- or 2-way, LRU replacement, flush of
// dirty lines on halt before raising flushed.
// Optional feature macro: WB_DCACHE_HIT_COUNTER_EN -- saturating count of
// hit cycles, written to HIT_CNT_ADDR after the flush scan.
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   dmemREN, dmemWEN     datapath read / write request (write has priority)
//   dmemaddr, dmemstore  byte address, write data
//   halt                 start flush (level)
//   dhit, dmemload       request served this cycle, read data
//   flushed              flush complete, held until reset
//   dREN, dWEN           memory read / write request
//   daddr, dstore        memory word address, write data
//   dload, dwait         memory read data, memory busy
// -----------------------------------------------------------------------------
module wb_dcache
    import wb_dcache_pkg::*;
#(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int WOFF_W = $clog2(BLKWORDS);
    localparam int WCNT_W = (WOFF_W == 0) ? 1 : WOFF_W;
    localparam int TAG_W  = 32 - 2 - WOFF_W - IDX_W;

    typedef struct packed {
        logic                      valid;
        logic                      dirty;
        logic [TAG_W-1:0]          tag;
        logic [BLKWORDS-1:0][31:0] data;
    } frame_t;

    function automatic word_t make_addr(input logic [TAG_W-1:0] tag,
                                        input logic [IDX_W-1:0] idx,
                                        input logic [WCNT_W-1:0] wrd);
        return (word_t'(tag) << (IDX_W + WOFF_W + 2)) |
               (word_t'(idx) << (WOFF_W + 2)) |
               (word_t'(wrd) << 2);
    endfunction

    frame_t             frames_q [SETS][WAYS];
    cache_state_t       state_q, state_d;
    logic [WCNT_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   set_q, set_d;
    logic               way_q, way_d;
    logic [TAG_W-1:0]   miss_tag_q;
    logic [IDX_W-1:0]   miss_idx_q;
    logic               victim_q;

    logic               req, hit, hit_way, victim;
    logic [WAYS-1:0]    way_match;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [WCNT_W-1:0]  req_word;
    logic               miss_start, fill_we, fill_done, flush_clr, scan_adv;
    logic               last_word;
    frame_t             wb_frame, scan_frame;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^dmemaddr[1:0];

    assign req     = dmemREN | dmemWEN;
    assign req_tag = dmemaddr[31 -: TAG_W];
    assign req_idx = dmemaddr[2 + WOFF_W +: IDX_W];

    generate
        if (BLKWORDS > 1) begin : g_woff
            assign req_word = dmemaddr[2 +: WOFF_W];
        end else begin : g_no_woff
            assign req_word = '0;
        end
    endgenerate

    always_comb begin
        way_match = '0;
        hit_way   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            way_match[w] = frames_q[req_idx][w].valid && (frames_q[req_idx][w].tag == req_tag);
            if (way_match[w]) hit_way = 1'(w);
        end
    end

    assign hit        = (state_q == IDLE) && req && (|way_match);
    assign wb_frame   = frames_q[miss_idx_q][victim_q];
    assign scan_frame = frames_q[set_q][way_q];
    assign last_word  = (word_q == WCNT_W'(BLKWORDS - 1));

    generate
        if (WAYS == 2) begin : g_lru
            wb_dcache_lru #(.SETS(SETS)) u_lru (
                .clk_i     (CLK),
                .rst_ni    (nRST),
                .hit_i     (hit),
                .hit_way_i (hit_way),
                .set_i     (req_idx),
                .valid_i   ({frames_q[req_idx][1].valid, frames_q[req_idx][0].valid}),
                .victim_o  (victim)
            );
        end else begin : g_direct
            assign victim = 1'b0;
        end
    endgenerate

`ifdef WB_DCACHE_HIT_COUNTER_EN
    word_t hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (dhit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_d = hit_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) hit_cnt_q <= '0;
        else       hit_cnt_q <= hit_cnt_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        set_d      = set_q;
        way_d      = way_q;
        dhit       = 1'b0;
        dmemload   = '0;
        flushed    = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        miss_start = 1'b0;
        fill_we    = 1'b0;
        fill_done  = 1'b0;
        flush_clr  = 1'b0;
        scan_adv   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    dhit     = 1'b1;
                    dmemload = frames_q[req_idx][hit_way].data[req_word];
                end else if (halt) begin
                    state_d = FLUSH;
                end else if (req) begin
                    miss_start = 1'b1;
                    if (frames_q[req_idx][victim].valid && frames_q[req_idx][victim].dirty)
                        state_d = WB;
                    else
                        state_d = FETCH;
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = make_addr(wb_frame.tag, miss_idx_q, word_q);
                dstore = wb_frame.data[word_q];
                if (!dwait) begin
                    if (last_word) begin
                        word_d  = '0;
                        state_d = FETCH;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = make_addr(miss_tag_q, miss_idx_q, word_q);
                if (!dwait) begin
                    fill_we = 1'b1;
                    if (last_word) begin
                        word_d    = '0;
                        fill_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (scan_frame.valid && scan_frame.dirty) begin
                    dWEN   = 1'b1;
                    daddr  = make_addr(scan_frame.tag, set_q, word_q);
                    dstore = scan_frame.data[word_q];
                    if (!dwait) begin
                        if (last_word) begin
                            word_d    = '0;
                            flush_clr = 1'b1;
                            scan_adv  = 1'b1;
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end
                end else begin
                    scan_adv = 1'b1;
                end
                // Scan order is set-major, way-minor.
                if (scan_adv) begin
                    if (way_q == 1'(WAYS - 1)) begin
                        way_d = 1'b0;
                        if (set_q == IDX_W'(SETS - 1)) begin
                            set_d = '0;
`ifdef WB_DCACHE_HIT_COUNTER_EN
                            state_d = CNTWR;
`else
                            state_d = DONE;
`endif
                        end else begin
                            set_d = set_q + 1'b1;
                        end
                    end else begin
                        way_d = way_q + 1'b1;
                    end
                end
            end
`ifdef WB_DCACHE_HIT_COUNTER_EN
            CNTWR: begin
                dWEN   = 1'b1;
                daddr  = HIT_CNT_ADDR;
                dstore = hit_cnt_q;
                if (!dwait) state_d = DONE;
            end
`endif
            DONE: begin
                flushed = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            word_q  <= '0;
            set_q   <= '0;
            way_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            set_q   <= set_d;
            way_q   <= way_d;
        end
    end

    // Miss context is captured once so the fill does not depend on the
    // datapath holding its address stable.
    always_ff @(posedge CLK) begin
        if (miss_start) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
            victim_q   <= victim;
        end
    end

    // Only valid/dirty are reset; tags and data are qualified by valid.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    frames_q[s][w].valid <= 1'b0;
                    frames_q[s][w].dirty <= 1'b0;
                end
            end
        end else begin
            if (hit && dmemWEN) begin
                frames_q[req_idx][hit_way].data[req_word] <= dmemstore;
                frames_q[req_idx][hit_way].dirty          <= 1'b1;
            end
            if (fill_we) begin
                frames_q[miss_idx_q][victim_q].data[word_q] <= dload;
            end
            if (fill_done) begin
                frames_q[miss_idx_q][victim_q].valid <= 1'b1;
                frames_q[miss_idx_q][victim_q].dirty <= 1'b0;
                frames_q[miss_idx_q][victim_q].tag   <= miss_tag_q;
            end
            if (flush_clr) begin
                frames_q[set_q][way_q].dirty <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_dcache.sv
// -----------------------------------------------------------------------------
// tb_wb_dcache
// Self-checking bench for wb_dcache (SETS=8, WAYS=2, BLKWORDS=2) with a
// behavioural memory that has a programmable number of wait states.
// -----------------------------------------------------------------------------
module tb_wb_dcache;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xact_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, halt;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore, dload;
    logic        dwait;

    int checks   = 0;
    int failures = 0;

    // Memory model state
    logic [31:0] mem [64];
    bit   [63:0] written;
    int          wait_states = 0;
    int          ws_cnt      = 0;
    int          unstable    = 0;
    logic [31:0] held_addr, held_data;
    xact_t       obs_q[$];
    xact_t       exp_q[$];
    logic [31:0] rd_exp_q[$];

    always #5 CLK = ~CLK;

    wb_dcache dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .halt      (halt),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .flushed   (flushed),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dwait     (dwait)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    always_comb begin
        if (written[daddr[7:2]])       dload = mem[daddr[7:2]];
        else if (daddr[7:2] == 6'd16)  dload = 32'hDEAD_BEEF;
        else                           dload = pat(daddr);
    end

    always_comb dwait = (dREN || dWEN) && (ws_cnt < wait_states);

    always @(posedge CLK) begin
        if (!nRST) begin
            ws_cnt <= 0;
        end else if (dREN || dWEN) begin
            if (ws_cnt != 0 && (daddr !== held_addr || dstore !== held_data))
                unstable <= unstable + 1;
            held_addr <= daddr;
            held_data <= dstore;
            if (dwait) begin
                ws_cnt <= ws_cnt + 1;
            end else begin
                ws_cnt <= 0;
                obs_q.push_back('{we: dWEN, addr: daddr, data: (dWEN ? dstore : dload)});
                if (dWEN) begin
                    mem[daddr[7:2]]     <= dstore;
                    written[daddr[7:2]] <= 1'b1;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
        dmemaddr = '0; dmemstore = '0;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Drives one request and waits (bounded) for dhit; ld captures read data.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int cyc, output logic [31:0] ld, output logic ok);
        @(negedge CLK);
        dmemWEN = wr; dmemREN = !wr; dmemaddr = addr; dmemstore = wdata;
        cyc = 0;
        #1;
        while (dhit !== 1'b1 && cyc < 200) begin
            @(negedge CLK); #1; cyc++;
        end
        ok = (dhit === 1'b1);
        ld = dmemload;
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (dhit !== 1'b0) begin failures++; $display("FAIL reset_dhit got=%b want=0", dhit); end
        checks++; if (flushed !== 1'b0) begin failures++; $display("FAIL reset_flushed got=%b want=0", flushed); end
        checks++; if ({dREN, dWEN} !== 2'b00) begin failures++; $display("FAIL reset_mem_req got=%b want=00", {dREN, dWEN}); end
        checks++; if (daddr !== 32'h0) begin failures++; $display("FAIL reset_daddr got=%h want=0", daddr); end
        checks++; if (dstore !== 32'h0 || dmemload !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h want=0/0", dstore, dmemload); end
    endtask

    task automatic test_cold_miss();
        int cyc; logic [31:0] ld; logic ok; xact_t e, o;
        obs_q.delete();
        rd_exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back('{we: 1'b0, addr: 32'h40, data: 32'hDEAD_BEEF});
        exp_q.push_back('{we: 1'b0, addr: 32'h44, data: pat(32'h44)});
        access(1'b0, 32'h40, 32'h0, cyc, ld, ok);
        checks++; if (!ok) begin failures++; $display("FAIL cold_timeout no dhit within bound"); end
        checks++; if (cyc != 3) begin failures++; $display("FAIL cold_latency got=%0d want=3", cyc); end
        e.data = rd_exp_q.pop_front();
        checks++; if (ld !== e.data) begin failures++; $display("FAIL cold_load got=%h want=%h", ld, e.data); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL cold_xact_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL cold_xact got we=%b a=%h d=%h want we=%b a=%h d=%h", o.we, o.addr, o.data, e.we, e.addr, e.data); end
        end
        exp_q.delete();
    endtask

    task automatic test_write_evict();
        int cyc; logic [31:0] ld; logic ok; xact_t e, o;
        obs_q.delete();
        // Write hit on the line filled by the cold miss.
        access(1'b1, 32'h40, 32'h1234, cyc, ld, ok);
        checks++; if (!ok || cyc != 0) begin failures++; $display("FAIL whit_latency got=%0d ok=%b want=0", cyc, ok); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL whit_no_mem got=%0d want=0", obs_q.size()); end
        // Fill the other way of set 0.
        access(1'b0, 32'h80, 32'h0, cyc, ld, ok);
        checks++; if (!ok || cyc != 3 || ld !== pat(32'h80)) begin failures++; $display("FAIL fill80 got cyc=%0d ld=%h want cyc=3 ld=%h", cyc, ld, pat(32'h80)); end
        obs_q.delete();
        // Third tag in set 0: LRU way holds dirty 0x40.
        exp_q.push_back('{we: 1'b1, addr: 32'h40, data: 32'h1234});
        exp_q.push_back('{we: 1'b1, addr: 32'h44, data: pat(32'h44)});
        exp_q.push_back('{we: 1'b0, addr: 32'hC0, data: pat(32'hC0)});
        exp_q.push_back('{we: 1'b0, addr: 32'hC4, data: pat(32'hC4)});
        rd_exp_q.push_back(pat(32'hC0));
        access(1'b0, 32'hC0, 32'h0, cyc, ld, ok);
        checks++; if (!ok || cyc != 5) begin failures++; $display("FAIL evict_latency got=%0d ok=%b want=5", cyc, ok); end
        e.data = rd_exp_q.pop_front();
        checks++; if (ld !== e.data) begin failures++; $display("FAIL evict_load got=%h want=%h", ld, e.data); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL evict_xact_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL evict_xact got we=%b a=%h d=%h want we=%b a=%h d=%h", o.we, o.addr, o.data, e.we, e.addr, e.data); end
        end
        exp_q.delete();
        // Re-read 0x40: evicts clean 0x80 and returns the written-back value.
        obs_q.delete();
        rd_exp_q.push_back(32'h1234);
        access(1'b0, 32'h40, 32'h0, cyc, ld, ok);
        e.data = rd_exp_q.pop_front();
        checks++; if (!ok || cyc != 3 || ld !== e.data) begin failures++; $display("FAIL reread40 got cyc=%0d ld=%h want cyc=3 ld=%h", cyc, ld, e.data); end
        checks++; if (obs_q.size() != 2 || obs_q[0].we !== 1'b0) begin failures++; $display("FAIL reread40_clean got n=%0d want=2 reads", obs_q.size()); end
    endtask

    task automatic test_wait_states();
        int cyc; logic [31:0] ld; logic ok; int u0; xact_t e, o;
        obs_q.delete();
        wait_states = 3;
        u0 = unstable;
        exp_q.push_back('{we: 1'b0, addr: 32'h10, data: pat(32'h10)});
        exp_q.push_back('{we: 1'b0, addr: 32'h14, data: pat(32'h14)});
        rd_exp_q.push_back(pat(32'h10));
        access(1'b0, 32'h10, 32'h0, cyc, ld, ok);
        wait_states = 0;
        checks++; if (!ok || cyc != 9) begin failures++; $display("FAIL wait_latency got=%0d ok=%b want=9", cyc, ok); end
        checks++; if (unstable != u0) begin failures++; $display("FAIL wait_stable got=%0d changes want=0", unstable - u0); end
        e.data = rd_exp_q.pop_front();
        checks++; if (ld !== e.data) begin failures++; $display("FAIL wait_load got=%h want=%h", ld, e.data); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            checks++; if (o !== e) begin failures++; $display("FAIL wait_xact got we=%b a=%h d=%h want we=%b a=%h d=%h", o.we, o.addr, o.data, e.we, e.addr, e.data); end
        end
    endtask

    task automatic test_flush();
        int cyc; logic [31:0] ld; logic ok; int n; xact_t e, o;
        do_reset();
        access(1'b1, 32'h08, 32'hAAAA_0008, cyc, ld, ok);   // set 1 way 0, dirty
        access(1'b0, 32'h28, 32'h0, cyc, ld, ok);           // set 5 way 0, clean
        access(1'b1, 32'h68, 32'hBBBB_0068, cyc, ld, ok);   // set 5 way 1, dirty
        checks++; if (!ok) begin failures++; $display("FAIL flush_setup no dhit within bound"); end
        obs_q.delete();
        exp_q.push_back('{we: 1'b1, addr: 32'h08, data: 32'hAAAA_0008});
        exp_q.push_back('{we: 1'b1, addr: 32'h0C, data: pat(32'h0C)});
        exp_q.push_back('{we: 1'b1, addr: 32'h68, data: 32'hBBBB_0068});
        exp_q.push_back('{we: 1'b1, addr: 32'h6C, data: pat(32'h6C)});
`ifdef WB_DCACHE_HIT_COUNTER_EN
        exp_q.push_back('{we: 1'b1, addr: 32'h3100, data: 32'd3});
`endif
        @(negedge CLK);
        halt = 1'b1;
        n = 0;
        #1;
        while (flushed !== 1'b1 && n < 200) begin @(negedge CLK); #1; n++; end
        checks++; if (flushed !== 1'b1) begin failures++; $display("FAIL flush_timeout flushed=%b want=1", flushed); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL flush_xact_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL flush_xact got we=%b a=%h d=%h want we=%b a=%h d=%h", o.we, o.addr, o.data, e.we, e.addr, e.data); end
        end
        exp_q.delete();
        // DONE: flushed held, no hits even on a resident line, no memory traffic.
        @(negedge CLK);
        halt = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h28;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({flushed, dhit, dREN, dWEN} !== 4'b1000) begin failures++; $display("FAIL done_hold got f/h/r/w=%b want=1000", {flushed, dhit, dREN, dWEN}); end
            @(negedge CLK);
        end
        dmemREN = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        int cyc; logic [31:0] ld; logic ok;
        do_reset();
        wait_states = 2;
        @(negedge CLK);
        dmemREN = 1'b1; dmemaddr = 32'h30;
        @(negedge CLK); #1;
        checks++; if (dREN !== 1'b1 || daddr !== 32'h30) begin failures++; $display("FAIL midrst_fetch got dREN=%b daddr=%h want 1/00000030", dREN, daddr); end
        nRST = 1'b0;
        @(posedge CLK); #1;
        checks++; if ({dhit, flushed, dREN, dWEN} !== 4'b0000 || daddr !== 32'h0 || dstore !== 32'h0 || dmemload !== 32'h0)
            begin failures++; $display("FAIL midrst_outputs got h/f/r/w=%b daddr=%h dstore=%h load=%h want all 0", {dhit, flushed, dREN, dWEN}, daddr, dstore, dmemload); end
        @(negedge CLK);
        nRST = 1'b1; dmemREN = 1'b0;
        wait_states = 0;
        obs_q.delete();
        access(1'b0, 32'h30, 32'h0, cyc, ld, ok);
        checks++; if (!ok || cyc != 3 || ld !== pat(32'h30)) begin failures++; $display("FAIL midrst_reread got cyc=%0d ld=%h want cyc=3 ld=%h", cyc, ld, pat(32'h30)); end
        checks++; if (obs_q.size() != 2 || obs_q[0].addr !== 32'h30) begin failures++; $display("FAIL midrst_refetch got n=%0d want=2 starting at 00000030", obs_q.size()); end
    endtask

    initial begin
        nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
        dmemaddr = '0; dmemstore = '0;
        test_reset();
        test_cold_miss();
        test_write_evict();
        test_wait_states();
        test_flush();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
